// File: rtl/demod_pkg.sv
// Shared definitions for the MPSK demodulator control blocks.
//   - frame FSM state encodings (ST_*)
//   - one-symbol period adjustment kinds (ADJ_*)
//   - minimum accepted samples-per-symbol and default widths
package demod_pkg;

  localparam int DEF_CNT_WIDTH = 8;
  localparam int DEF_LEN_WIDTH = 16;
  localparam int SPS_MIN       = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_TRACK = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ADJ_NONE  = 2'd0,
    ADJ_EARLY = 2'd1,
    ADJ_LATE  = 2'd2
  } adj_t;

endpackage

// File: rtl/sym_phase_cnt.sv
// Sample-phase counter and symbol strobe generator.
//   clk, rstn         : clock, async active-low reset
//   en                : counting enable (ACQ/TRACK); phase and pending
//                       adjustment are cleared while low
//   sps               : latched samples per symbol
//   adj_early/late    : period nudge, sampled only in the strobe cycle
//   stb               : high on the last sample of the current period
module sym_phase_cnt
  import demod_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] sps,
  input  logic                 adj_early,
  input  logic                 adj_late,
  output logic                 stb
);

  localparam logic [CNT_WIDTH:0] ONE_P = {{CNT_WIDTH{1'b0}}, 1'b1};

  adj_t                 adj_q;
  logic [CNT_WIDTH-1:0] phase_q;
  logic [CNT_WIDTH:0]   period;
  logic [CNT_WIDTH:0]   last;

  // One extra bit so sps+1 cannot wrap; the phase itself still fits in
  // CNT_WIDTH bits because its maximum is period-1 = sps.
  always_comb begin
    period = {1'b0, sps};
    case (adj_q)
      ADJ_EARLY: period = {1'b0, sps} - ONE_P;
      ADJ_LATE:  period = {1'b0, sps} + ONE_P;
      default:   period = {1'b0, sps};
    endcase
    last = period - ONE_P;
  end

  assign stb = en && ({1'b0, phase_q} == last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q <= '0;
      adj_q   <= ADJ_NONE;
    end else if (!en) begin
      phase_q <= '0;
      adj_q   <= ADJ_NONE;
    end else if (stb) begin
      phase_q <= '0;
      // Conflicting nudges cancel; the choice lasts exactly one period.
      if (adj_early && !adj_late)      adj_q <= ADJ_EARLY;
      else if (adj_late && !adj_early) adj_q <= ADJ_LATE;
      else                             adj_q <= ADJ_NONE;
    end else begin
      phase_q <= phase_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/sym_sched.sv
// Symbol-rate scheduler: frame sequencing (preamble, data, flush) and
// per-stage load enables for the downstream clear-when-disabled chain.
//   clk, rstn                  : clock, async active-low reset
//   start, abort               : frame request (IDLE only) / sync abort
//   sps, pre_len, data_len     : frame configuration, latched at start
//   adj_early, adj_late        : timing-loop nudges for the next period
//   busy, state, sym_idx       : frame status
//   sym_stb, stage_en          : symbol strobe and stage load enables
//   pre_done, frame_done       : end-of-preamble / end-of-frame pulses
//   cfg_err                    : pulse after a rejected start
//
// state | meaning
// IDLE  | waiting for an acceptable start
// ACQ   | preamble symbols, pre_done on the last one
// TRACK | data symbols, each strobe launches stage_en[0]
// FLUSH | NSTAGE cycles draining the stage pipeline, no strobes
module sym_sched
  import demod_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH,
  parameter int NSTAGE    = 4            // must be >= 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] sps,
  input  logic [LEN_WIDTH-1:0] pre_len,
  input  logic [LEN_WIDTH-1:0] data_len,
  input  logic                 adj_early,
  input  logic                 adj_late,
  output logic                 busy,
  output logic [1:0]           state,
  output logic                 sym_stb,
  output logic [NSTAGE-1:0]    stage_en,
  output logic                 pre_done,
  output logic                 frame_done,
  output logic [LEN_WIDTH-1:0] sym_idx,
  output logic                 cfg_err
);

  localparam int                 FW         = $clog2(NSTAGE);
  localparam int                 DW         = NSTAGE - 1;
  localparam logic [FW-1:0]      FLUSH_LAST = FW'(NSTAGE - 1);
  localparam logic [LEN_WIDTH-1:0] ONE_L    = LEN_WIDTH'(1);

  state_t               st_q;
  logic [CNT_WIDTH-1:0] sps_q;
  logic [LEN_WIDTH-1:0] pre_len_q;
  logic [LEN_WIDTH-1:0] data_len_q;
  logic [LEN_WIDTH-1:0] idx_q;
  logic [FW-1:0]        flush_q;
  logic [DW-1:0]        dly_q;
  logic                 cfg_err_q;
  logic                 run, stb, en0;
  logic                 cfg_ok, last_pre, last_data, last_flush;

  assign run = (st_q == ST_ACQ) || (st_q == ST_TRACK);

  sym_phase_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_phase (
    .clk       (clk),
    .rstn      (rstn),
    .en        (run),
    .sps       (sps_q),
    .adj_early (adj_early),
    .adj_late  (adj_late),
    .stb       (stb)
  );

  assign cfg_ok     = (sps >= CNT_WIDTH'(SPS_MIN)) && (data_len != '0);
  assign last_pre   = (idx_q == pre_len_q - ONE_L);
  assign last_data  = (idx_q == data_len_q - ONE_L);
  assign last_flush = (flush_q == FLUSH_LAST);
  assign en0        = (st_q == ST_TRACK) && stb;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q       <= ST_IDLE;
      sps_q      <= '0;
      pre_len_q  <= '0;
      data_len_q <= '0;
      idx_q      <= '0;
      flush_q    <= '0;
      dly_q      <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      if (abort) begin
        st_q    <= ST_IDLE;
        idx_q   <= '0;
        flush_q <= '0;
        dly_q   <= '0;
      end else begin
        // Cast keeps the low DW bits: stage_en[i] -> stage_en[i+1].
        dly_q <= DW'({dly_q, en0});
        case (st_q)
          ST_IDLE: begin
            if (start) begin
              if (cfg_ok) begin
                sps_q      <= sps;
                pre_len_q  <= pre_len;
                data_len_q <= data_len;
                idx_q      <= '0;
                st_q       <= (pre_len != '0) ? ST_ACQ : ST_TRACK;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          ST_ACQ: begin
            if (stb) begin
              if (last_pre) begin
                st_q  <= ST_TRACK;
                idx_q <= '0;
              end else begin
                idx_q <= idx_q + ONE_L;
              end
            end
          end
          ST_TRACK: begin
            if (stb) begin
              if (last_data) begin
                st_q    <= ST_FLUSH;
                idx_q   <= '0;
                flush_q <= '0;
              end else begin
                idx_q <= idx_q + ONE_L;
              end
            end
          end
          ST_FLUSH: begin
            if (last_flush) begin
              st_q    <= ST_IDLE;
              flush_q <= '0;
            end else begin
              flush_q <= flush_q + FW'(1);
            end
          end
          default: st_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy       = (st_q != ST_IDLE);
  assign state      = st_q;
  assign sym_stb    = stb;
  assign stage_en   = {dly_q, en0};
  assign pre_done   = (st_q == ST_ACQ) && stb && last_pre;
  assign frame_done = (st_q == ST_FLUSH) && last_flush;
  assign sym_idx    = idx_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_sym_sched.sv
module tb_sym_sched;

  localparam int CW  = 8;
  localparam int LW  = 16;
  localparam int NST = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0, abort = 1'b0, adj_early = 1'b0, adj_late = 1'b0;
  logic [CW-1:0] sps = '0;
  logic [LW-1:0] pre_len = '0, data_len = '0;
  logic          busy, sym_stb, pre_done, frame_done, cfg_err;
  logic [1:0]    state;
  logic [NST-1:0] stage_en;
  logic [LW-1:0] sym_idx;

  sym_sched #(.CNT_WIDTH(CW), .LEN_WIDTH(LW), .NSTAGE(NST)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .sps(sps), .pre_len(pre_len), .data_len(data_len),
    .adj_early(adj_early), .adj_late(adj_late),
    .busy(busy), .state(state), .sym_stb(sym_stb), .stage_en(stage_en),
    .pre_done(pre_done), .frame_done(frame_done), .sym_idx(sym_idx),
    .cfg_err(cfg_err)
  );

  typedef struct packed {
    int             cyc;
    logic [1:0]     st;
    logic           busy, stb, pre, fd, cerr;
    logic [NST-1:0] se;
    logic [LW-1:0]  idx;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d expected events pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  function automatic logic [26:0] pack(input ev_t e);
    return {e.st, e.busy, e.stb, e.pre, e.fd, e.cerr, e.se, e.idx};
  endfunction

  // Monitor: every cycle with visible output activity consumes one expected event.
  ev_t         mon_e;
  logic [26:0] mon_act;
  always @(negedge clk) begin
    if (rstn) begin
      mon_act = {state, busy, sym_stb, pre_done, frame_done, cfg_err, stage_en, sym_idx};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        n_tests++; n_fail++;
        $display("FAIL missed_event cyc=%0d got=none expected=%h", mon_e.cyc, pack(mon_e));
      end
      if (sym_stb || pre_done || frame_done || cfg_err || (stage_en != '0)) begin
        n_tests++;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          mon_e = exp_q.pop_front();
          if (mon_act !== pack(mon_e)) begin
            n_fail++;
            $display("FAIL event cyc=%0d got=%h expected=%h", cyc, mon_act, pack(mon_e));
          end
        end else begin
          n_fail++;
          $display("FAIL unexpected_event cyc=%0d got=%h expected=none", cyc, mon_act);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, expv);
    end
  endtask

  // mode: 0 normal, 1 abort while stage_en[1] of first data symbol,
  // 2 reset mid-preamble, 3 start held through flush, 4 random abort,
  // 5 abort together with start. adj_code<0: random nudges, else 2 bits
  // per strobe (bit0 early, bit1 late).
  task automatic run_frame(input int sv, input int pv, input int dv,
                           input int mode, input int adj_code);
    int   k, n, tt, tend, a, r, lim, last, L, c, d, code, p, cnt;
    int   ts[$];
    int   adjm[int];
    ev_t  rec[];
    ev_t  e;
    k = cyc;
    if (!(sv >= 2 && dv != 0)) begin
      e = '0; e.cyc = k + 1; e.cerr = 1'b1;
      exp_q.push_back(e);
      sps = CW'(sv); pre_len = LW'(pv); data_len = LW'(dv);
      start = 1'b1; abort = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      check("reject_stays_idle", {busy, state}, 0);
      return;
    end
    n = pv + dv;
    tt = k + sv;
    for (int j = 0; j < n; j++) begin
      ts.push_back(tt);
      code = (adj_code < 0) ? int'($urandom_range(0, 3)) : ((adj_code >> (2 * j)) & 3);
      adjm[tt] = code;
      d = (code == 1) ? -1 : (code == 2) ? 1 : 0;
      tt = tt + sv + d;
    end
    tend = ts[n-1] + NST;
    a = -1; r = -1; lim = tend;
    if (mode == 1) a = ts[pv] + 1;
    if (mode == 4) a = int'($urandom_range(tend, k));
    if (mode == 5) a = k;
    if (mode == 2) r = int'($urandom_range(ts[pv-1], k + 1));
    if (a >= 0) lim = a;
    if (r >= 0) lim = r - 1;

    L = tend - k;
    rec = new[L];
    for (int i = 0; i < L; i++) begin
      c = k + 1 + i;
      rec[i] = '0;
      rec[i].cyc = c;
      rec[i].busy = 1'b1;
      cnt = 0;
      if (pv > 0 && c <= ts[pv-1]) begin
        rec[i].st = 2'd1;
        for (int j = 0; j < pv; j++) if (ts[j] < c) cnt++;
      end else if (c <= ts[n-1]) begin
        rec[i].st = 2'd2;
        for (int j = pv; j < n; j++) if (ts[j] < c) cnt++;
      end else begin
        rec[i].st = 2'd3;
      end
      rec[i].idx = LW'(cnt);
    end
    for (int j = 0; j < n; j++) begin
      p = ts[j] - k - 1;
      rec[p].stb = 1'b1;
      if (j == pv - 1) rec[p].pre = 1'b1;
      if (j >= pv) for (int i = 0; i < NST; i++) rec[p+i].se[i] = 1'b1;
    end
    rec[L-1].fd = 1'b1;
    for (int i = 0; i < L; i++)
      if (rec[i].cyc <= lim && (rec[i].stb || rec[i].fd || rec[i].se != '0))
        exp_q.push_back(rec[i]);

    last = (r >= 0) ? r - 1 : (a >= 0) ? a : tend;
    for (c = k; c <= last; c++) begin
      if (c == k) begin
        sps = CW'(sv); pre_len = LW'(pv); data_len = LW'(dv);
      end else begin
        sps = CW'($urandom_range(0, 255));
        pre_len = LW'($urandom_range(0, 7));
        data_len = LW'($urandom_range(0, 7));
      end
      start = (c == k) || (mode == 3 && c > ts[n-1]);
      abort = (c == a);
      if (adjm.exists(c)) {adj_late, adj_early} = 2'(adjm[c]);
      else                {adj_late, adj_early} = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; adj_early = 1'b0; adj_late = 1'b0;
    if (r >= 0) begin
      #1 rstn = 1'b0;
      #1;
      check("reset_async_outputs",
            {busy, state, sym_stb, pre_done, frame_done, cfg_err, stage_en, sym_idx}, 0);
      @(posedge clk); #1 rstn = 1'b1;
    end
    check("idle_after_frame", {busy, state, stage_en, frame_done}, 0);
  endtask

  int sv, pv, dv, m, mode;

  initial begin
    #3;
    check("reset_outputs",
          {busy, state, sym_stb, pre_done, frame_done, cfg_err, stage_en, sym_idx}, 0);
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;

    run_frame(4, 2, 3, 0, 0);    // strobes +4..+20, pre_done +8, frame_done +24
    run_frame(1, 2, 3, 0, 0);    // sps too small
    run_frame(4, 1, 0, 0, 0);    // empty data section
    run_frame(5, 2, 2, 0, 9);    // early then late: strobes +5,+9,+15,+20
    run_frame(4, 1, 3, 1, -1);
    run_frame(2, 0, 1, 0, 0);    // straight to TRACK
    run_frame(4, 3, 2, 2, -1);
    run_frame(3, 1, 2, 3, -1);
    run_frame(4, 1, 2, 5, -1);
    run_frame(2, 1, 3, 0, -1);

    for (int i = 0; i < 40; i++) begin
      sv = int'($urandom_range(1, 6));
      pv = int'($urandom_range(0, 3));
      dv = int'($urandom_range(0, 4));
      m  = int'($urandom_range(0, 7));
      case (m)
        3:       mode = 1;
        4:       mode = (pv > 0) ? 2 : 0;
        5:       mode = 3;
        6:       mode = 4;
        7:       mode = 5;
        default: mode = 0;
      endcase
      run_frame(sv, pv, dv, mode, -1);
    end

    repeat (8) @(posedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_events got=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
